vx_commit_gather: RTL and testbench
===================================

Name: vx_commit_gather

Overview:
- Consumer (slave) end of the commit valid/ready channel.
- Accepts lane-sliced commit packets from an execute unit. Each packet carries NUM_LANES lanes, plus a pid/sop/eop sequence.
- Reassembles the packets of one instruction into a full NUM_THREADS-wide writeback request for the register-file writeback port.
- Keeps a retired-instruction counter for the commit/CSR logic.

Parameters:
- NUM_THREADS, 8, threads per warp (output width).
- NUM_LANES, 4, lanes per commit packet; NUM_THREADS % NUM_LANES == 0.
- PID_WIDTH, LOG2UP(NUM_THREADS/NUM_LANES), packet index width.
- XLEN, 32, data word width.
- NW_WIDTH, 2, warp id width.
- NR_BITS, 6, register index width.
- UUID_WIDTH, 1, instruction uuid width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- commit_valid  in  1  packet valid
- commit_uuid  in  UUID_WIDTH  instruction uuid
- commit_wid  in  NW_WIDTH  warp id
- commit_tmask  in  NUM_LANES  lane mask of this packet
- commit_PC  in  XLEN  instruction PC
- commit_wb  in  1  instruction writes rd
- commit_rd  in  NR_BITS  destination register
- commit_data  in  NUM_LANES*XLEN  lane results
- commit_pid  in  PID_WIDTH  packet index
- commit_sop  in  1  first packet of instruction
- commit_eop  in  1  last packet of instruction
- commit_ready  out  1  packet accepted when valid&ready
- wb_valid  out  1  writeback request valid
- wb_uuid  out  UUID_WIDTH  uuid
- wb_wid  out  NW_WIDTH  warp id
- wb_PC  out  XLEN  PC
- wb_rd  out  NR_BITS  destination register
- wb_tmask  out  NUM_THREADS  assembled thread mask
- wb_data  out  NUM_THREADS*XLEN  assembled data
- wb_ready  in  1  writeback consumer ready
- retired_count  out  32  instructions retired, wraps modulo 2^32
- proto_err  out  1  sticky sequencing-error flag

Behaviour:
- States: IDLE, COLLECT, FULL. On reset: state IDLE; wb_valid 0; wb_tmask 0; wb_data 0; other wb_* 0; retired_count 0; proto_err 0. Reset asserted mid-operation discards any partial instruction immediately.
- Accept condition (accept): commit_valid & commit_ready.
- commit_ready is 1 in IDLE and COLLECT. In FULL it equals wb_ready (drain and refill in the same cycle).
- On every accepted packet:
  - tmask bits written at lane offset pid*NUM_LANES.
  - data words written at the same lane offset.
  - Lanes not covered by the packet keep their value.
- sop=1 accept:
  - Clears the assembled tmask/data before merging.
  - Latches uuid, wid, PC, wb, rd.
  - Next state is COLLECT, or completes at once if eop=1.
- sop=0 accept in COLLECT:
  - Merges the packet.
  - wid differing from the latched wid sets proto_err; the packet is still merged.
- sop=0 accept in IDLE: packet dropped, proto_err set.
- sop=1 accept in COLLECT: partial instruction discarded, proto_err set, new instruction started.
- eop=1 accept:
  - retired_count increments in the following cycle.
  - If the latched/new wb=1: next state FULL, wb_valid=1 registered, so 1 cycle after the eop accept.
  - If wb=0: no writeback issued, next state IDLE.
- FULL:
  - wb_* outputs stable while wb_valid & ~wb_ready.
  - On wb_valid & wb_ready: wb_valid drops the next cycle unless a packet accepted in that same cycle is sop&eop with wb=1; that instruction is output next cycle, keeping wb_valid high with no bubble.
  - If the same-cycle packet is sop without eop: state goes to COLLECT.
- Latency: last packet accept to wb_valid is 1 cycle.
- Throughput: one instruction per max(packets, 1) cycles while wb_ready is held high.
- retired_count is unaffected by dropped packets. proto_err clears only on reset.

Test Plan:
- NUM_THREADS=8, NUM_LANES=4. Send pid0 {sop, tmask=4'hF, data 1..4} then pid1 {eop, tmask=4'h3, data 5..8}, wb=1, rd=5, wid=2, wb_ready=1 -> one cycle after the eop: wb_valid=1, wb_tmask=8'h3F, wb_data lanes 0-5 = 1..6, wb_rd=5, wb_wid=2. retired_count=1.
- Single-packet sop&eop instruction with wb=0 -> wb_valid never asserts, retired_count increments by 1, state back to IDLE.
- Hold wb_ready=0 for 5 cycles after completion -> wb_* stable, commit_ready=0. Raise wb_ready while a sop&eop wb=1 packet waits -> both handshakes fire the same cycle, new request appears next cycle with no bubble.
- Packet with sop=0 while IDLE -> dropped, proto_err=1, retired_count unchanged, no wb_valid.
- sop packet, then a second sop packet before eop -> first instruction discarded, proto_err=1. After the eop, only the second instruction is written back.
- Assert reset in COLLECT after one packet -> wb_valid=0, retired_count=0, proto_err=0 asynchronously. A later complete instruction assembles correctly.

Source files
------------

// File: rtl/vx_commit_gather.sv
// Commit-channel consumer: gathers lane-sliced commit packets of one instruction
// into a full-warp writeback request and counts retired instructions.
module vx_commit_gather #(
  parameter int NUM_THREADS = 8,
  parameter int NUM_LANES   = 4,
  parameter int PID_WIDTH   = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1,
  parameter int XLEN        = 32,
  parameter int NW_WIDTH    = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_WIDTH  = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         commit_valid,
  input  logic [UUID_WIDTH-1:0]        commit_uuid,
  input  logic [NW_WIDTH-1:0]          commit_wid,
  input  logic [NUM_LANES-1:0]         commit_tmask,
  input  logic [XLEN-1:0]              commit_PC,
  input  logic                         commit_wb,
  input  logic [NR_BITS-1:0]           commit_rd,
  input  logic [NUM_LANES*XLEN-1:0]    commit_data,
  input  logic [PID_WIDTH-1:0]         commit_pid,
  input  logic                         commit_sop,
  input  logic                         commit_eop,
  output logic                         commit_ready,
  output logic                         wb_valid,
  output logic [UUID_WIDTH-1:0]        wb_uuid,
  output logic [NW_WIDTH-1:0]          wb_wid,
  output logic [XLEN-1:0]              wb_PC,
  output logic [NR_BITS-1:0]           wb_rd,
  output logic [NUM_THREADS-1:0]       wb_tmask,
  output logic [NUM_THREADS*XLEN-1:0]  wb_data,
  input  logic                         wb_ready,
  output logic [31:0]                  retired_count,
  output logic                         proto_err
);

  localparam int NUM_PKTS = NUM_THREADS / NUM_LANES;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_FULL
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [UUID_WIDTH-1:0] r_uuid;
  logic [NW_WIDTH-1:0]   r_wid;
  logic [XLEN-1:0]       r_pc;
  logic                  r_wb;
  logic [NR_BITS-1:0]    r_rd;
  logic [31:0]           r_retired;
  logic                  r_err;

  logic [NUM_LANES-1:0]      r_tmask_slot [NUM_PKTS];
  logic [NUM_LANES*XLEN-1:0] r_data_slot  [NUM_PKTS];

  logic w_accept;
  logic w_open;
  logic w_start;
  logic w_merge;
  logic w_drop;
  logic w_take;
  logic w_done;
  logic w_done_wb;
  logic w_err;

  // A FULL buffer can take a new packet only in the cycle it is being drained.
  assign commit_ready = (r_state != S_FULL) | wb_ready;
  assign w_accept     = commit_valid & commit_ready;
  assign w_open       = (r_state == S_COLLECT);
  assign w_start      = w_accept & commit_sop;
  assign w_merge      = w_accept & ~commit_sop & w_open;
  assign w_drop       = w_accept & ~commit_sop & ~w_open;
  assign w_take       = w_start | w_merge;
  assign w_done       = w_take & commit_eop;
  assign w_done_wb    = w_start ? commit_wb : r_wb;
  assign w_err        = w_drop
                      | (w_start & w_open)
                      | (w_merge & (commit_wid != r_wid));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_take) begin
      if (commit_eop) begin
        w_state_next = w_done_wb ? S_FULL : S_IDLE;
      end else begin
        w_state_next = S_COLLECT;
      end
    end else if ((r_state == S_FULL) && wb_ready) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_uuid <= '0;
      r_wid  <= '0;
      r_pc   <= '0;
      r_wb   <= 1'b0;
      r_rd   <= '0;
    end else if (w_start) begin
      r_uuid <= commit_uuid;
      r_wid  <= commit_wid;
      r_pc   <= commit_PC;
      r_wb   <= commit_wb;
      r_rd   <= commit_rd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retired <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_done) begin
        r_retired <= r_retired + 32'd1;
      end
      if (w_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // One storage slot per packet index; a sop clears every slot it does not write.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PKTS; gi++) begin : g_slot
      logic w_hit;
      assign w_hit = (commit_pid == PID_WIDTH'(gi));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_tmask_slot[gi] <= '0;
          r_data_slot[gi]  <= '0;
        end else if (w_take && w_hit) begin
          r_tmask_slot[gi] <= commit_tmask;
          r_data_slot[gi]  <= commit_data;
        end else if (w_start) begin
          r_tmask_slot[gi] <= '0;
          r_data_slot[gi]  <= '0;
        end
      end

      assign wb_tmask[gi*NUM_LANES +: NUM_LANES]          = r_tmask_slot[gi];
      assign wb_data[gi*NUM_LANES*XLEN +: NUM_LANES*XLEN] = r_data_slot[gi];
    end
  endgenerate

  assign wb_valid      = (r_state == S_FULL);
  assign wb_uuid       = r_uuid;
  assign wb_wid        = r_wid;
  assign wb_PC         = r_pc;
  assign wb_rd         = r_rd;
  assign retired_count = r_retired;
  assign proto_err     = r_err;

endmodule

// File: tb/tb_vx_commit_gather.sv
// Bench for vx_commit_gather: instruction table plus hand-written corner sequences,
// writeback requests checked against a queue of expected results.
module tb_vx_commit_gather;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         commit_valid = 1'b0;
  logic [0:0]   commit_uuid = '0;
  logic [1:0]   commit_wid = '0;
  logic [3:0]   commit_tmask = '0;
  logic [31:0]  commit_PC = '0;
  logic         commit_wb = 1'b0;
  logic [5:0]   commit_rd = '0;
  logic [127:0] commit_data = '0;
  logic [0:0]   commit_pid = '0;
  logic         commit_sop = 1'b0;
  logic         commit_eop = 1'b0;
  logic         commit_ready;
  logic         wb_valid;
  logic [0:0]   wb_uuid;
  logic [1:0]   wb_wid;
  logic [31:0]  wb_PC;
  logic [5:0]   wb_rd;
  logic [7:0]   wb_tmask;
  logic [255:0] wb_data;
  logic         wb_ready = 1'b1;
  logic [31:0]  retired_count;
  logic         proto_err;

  vx_commit_gather dut (
    .clk(clk), .reset(reset),
    .commit_valid(commit_valid), .commit_uuid(commit_uuid), .commit_wid(commit_wid),
    .commit_tmask(commit_tmask), .commit_PC(commit_PC), .commit_wb(commit_wb),
    .commit_rd(commit_rd), .commit_data(commit_data), .commit_pid(commit_pid),
    .commit_sop(commit_sop), .commit_eop(commit_eop), .commit_ready(commit_ready),
    .wb_valid(wb_valid), .wb_uuid(wb_uuid), .wb_wid(wb_wid), .wb_PC(wb_PC),
    .wb_rd(wb_rd), .wb_tmask(wb_tmask), .wb_data(wb_data), .wb_ready(wb_ready),
    .retired_count(retired_count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  wid;
    logic [5:0]  rd;
    logic [0:0]  uuid;
    logic [31:0] pc;
    logic [7:0]  tmask;
    logic [255:0] data;
  } exp_t;

  typedef struct {
    logic [1:0]  wid;
    logic [5:0]  rd;
    logic [0:0]  uuid;
    logic [31:0] pc;
    logic        wb;
    logic        two;
    logic [0:0]  spid;
    logic [3:0]  tm0;
    logic [3:0]  tm1;
    logic [31:0] base;
    logic [7:0]  exp_tmask;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_ret  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Word for thread t is base+t wherever that thread's packet slot was written.
  function automatic logic [255:0] mk_data(input logic [31:0] base, input logic [1:0] slots);
    logic [255:0] d;
    d = '0;
    for (int t = 0; t < 8; t++) begin
      if (slots[t/4]) d[t*32 +: 32] = base + 32'(t);
    end
    return d;
  endfunction

  task automatic drive(input logic sop, input logic eop, input logic [0:0] pid,
                       input logic [3:0] tm, input logic [1:0] wid, input logic [5:0] rd,
                       input logic [0:0] uuid, input logic [31:0] pc, input logic wb,
                       input logic [31:0] base);
    commit_sop   = sop;
    commit_eop   = eop;
    commit_pid   = pid;
    commit_tmask = tm;
    commit_wid   = wid;
    commit_rd    = rd;
    commit_uuid  = uuid;
    commit_PC    = pc;
    commit_wb    = wb;
    for (int l = 0; l < 4; l++) commit_data[l*32 +: 32] = base + 32'(pid) * 32'd4 + 32'(l);
    commit_valid = 1'b1;
  endtask

  // Returns at active edge + 1 time unit, right after the packet was accepted.
  task automatic send(input logic sop, input logic eop, input logic [0:0] pid,
                      input logic [3:0] tm, input logic [1:0] wid, input logic [5:0] rd,
                      input logic [0:0] uuid, input logic [31:0] pc, input logic wb,
                      input logic [31:0] base);
    int n;
    drive(sop, eop, pid, tm, wid, rd, uuid, pc, wb, base);
    n = 0;
    @(negedge clk);
    while (!commit_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got commit_ready=0 for 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("drain", 256'(sb.size()), 256'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wb: got request tmask=%h rd=%0d wid=%0d, required none",
                 wb_tmask, wb_rd, wb_wid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (wb_tmask !== e.tmask || wb_data !== e.data || wb_wid !== e.wid ||
            wb_rd !== e.rd || wb_PC !== e.pc || wb_uuid !== e.uuid) begin
          n_fail++;
          $display("FAIL wb_txn: got tmask=%h wid=%0d rd=%0d pc=%h uuid=%0d data=%h, required tmask=%h wid=%0d rd=%0d pc=%h uuid=%0d data=%h",
                   wb_tmask, wb_wid, wb_rd, wb_PC, wb_uuid, wb_data,
                   e.tmask, e.wid, e.rd, e.pc, e.uuid, e.data);
        end else begin
          $display("wb txn ok: tmask=%h wid=%0d rd=%0d pc=%h", wb_tmask, wb_wid, wb_rd, wb_PC);
        end
      end
    end
  end

  initial begin
    vec_t vecs[6];
    exp_t e;
    exp_t y;

    vecs[0] = '{wid:2'd2, rd:6'd5,  uuid:1'b0, pc:32'h100, wb:1'b1, two:1'b1, spid:1'b0, tm0:4'hF, tm1:4'h3, base:32'd1,      exp_tmask:8'h3F};
    vecs[1] = '{wid:2'd1, rd:6'd3,  uuid:1'b1, pc:32'h104, wb:1'b0, two:1'b0, spid:1'b0, tm0:4'hF, tm1:4'h0, base:32'h10,     exp_tmask:8'h0F};
    vecs[2] = '{wid:2'd3, rd:6'd7,  uuid:1'b1, pc:32'h108, wb:1'b1, two:1'b0, spid:1'b1, tm0:4'hA, tm1:4'h0, base:32'h20,     exp_tmask:8'hA0};
    vecs[3] = '{wid:2'd0, rd:6'd0,  uuid:1'b0, pc:32'h10C, wb:1'b1, two:1'b1, spid:1'b0, tm0:4'h0, tm1:4'hF, base:32'h30,     exp_tmask:8'hF0};
    vecs[4] = '{wid:2'd1, rd:6'd63, uuid:1'b0, pc:32'h110, wb:1'b1, two:1'b0, spid:1'b0, tm0:4'h5, tm1:4'h0, base:32'hABC0,   exp_tmask:8'h05};
    vecs[5] = '{wid:2'd2, rd:6'd9,  uuid:1'b1, pc:32'h114, wb:1'b0, two:1'b1, spid:1'b0, tm0:4'h9, tm1:4'h6, base:32'h50,     exp_tmask:8'h69};

    // Reset state
    #12;
    check("rst_wb_valid", 256'(wb_valid), 256'd0);
    check("rst_wb_tmask", 256'(wb_tmask), 256'd0);
    check("rst_wb_data", wb_data, 256'd0);
    check("rst_retired", 256'(retired_count), 256'd0);
    check("rst_proto_err", 256'(proto_err), 256'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ready", 256'(commit_ready), 256'd1);

    // Instruction table, wb_ready held high
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wb) begin
        e.wid   = vecs[i].wid;
        e.rd    = vecs[i].rd;
        e.uuid  = vecs[i].uuid;
        e.pc    = vecs[i].pc;
        e.tmask = vecs[i].exp_tmask;
        e.data  = mk_data(vecs[i].base, vecs[i].two ? 2'b11 : (vecs[i].spid ? 2'b10 : 2'b01));
        sb.push_back(e);
      end
      if (vecs[i].two) begin
        send(1'b1, 1'b0, 1'b0, vecs[i].tm0, vecs[i].wid, vecs[i].rd, vecs[i].uuid, vecs[i].pc, vecs[i].wb, vecs[i].base);
        send(1'b0, 1'b1, 1'b1, vecs[i].tm1, vecs[i].wid, vecs[i].rd, vecs[i].uuid, vecs[i].pc, vecs[i].wb, vecs[i].base);
      end else begin
        send(1'b1, 1'b1, vecs[i].spid, vecs[i].tm0, vecs[i].wid, vecs[i].rd, vecs[i].uuid, vecs[i].pc, vecs[i].wb, vecs[i].base);
      end
      exp_ret++;
      $display("vec %0d sent: wb=%0d two=%0d retired=%0d", i, vecs[i].wb, vecs[i].two, retired_count);
      check($sformatf("vec%0d_latency_wb_valid", i), 256'(wb_valid), 256'(vecs[i].wb));
      check($sformatf("vec%0d_retired", i), 256'(retired_count), 256'(exp_ret));
    end
    wait_drain();
    @(posedge clk);
    #1;
    check("table_idle_wb_valid", 256'(wb_valid), 256'd0);
    check("table_proto_err", 256'(proto_err), 256'd0);

    // Backpressure then drain-and-refill in the same cycle
    wb_ready = 1'b0;
    e = '{wid:2'd3, rd:6'd11, uuid:1'b1, pc:32'h200, tmask:8'h0C, data:mk_data(32'h700, 2'b01)};
    sb.push_back(e);
    send(1'b1, 1'b1, 1'b0, 4'hC, 2'd3, 6'd11, 1'b1, 32'h200, 1'b1, 32'h700);
    exp_ret++;
    check("bp_wb_valid", 256'(wb_valid), 256'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_commit_ready", 256'(commit_ready), 256'd0);
      check("bp_stable_tmask", 256'(wb_tmask), 256'(e.tmask));
      check("bp_stable_data", wb_data, e.data);
      check("bp_stable_valid", 256'(wb_valid), 256'd1);
    end
    @(posedge clk);
    #1;
    y = '{wid:2'd0, rd:6'd12, uuid:1'b0, pc:32'h204, tmask:8'h70, data:mk_data(32'h800, 2'b10)};
    sb.push_back(y);
    drive(1'b1, 1'b1, 1'b1, 4'h7, 2'd0, 6'd12, 1'b0, 32'h204, 1'b1, 32'h800);
    @(negedge clk);
    check("bp_wait_ready", 256'(commit_ready), 256'd0);
    @(posedge clk);
    #1;
    wb_ready = 1'b1;
    @(negedge clk);
    check("refill_ready", 256'(commit_ready), 256'd1);
    @(posedge clk);
    #1;
    commit_valid = 1'b0;
    exp_ret++;
    check("refill_no_bubble", 256'(wb_valid), 256'd1);
    check("refill_tmask", 256'(wb_tmask), 256'(y.tmask));
    check("refill_retired", 256'(retired_count), 256'(exp_ret));
    @(posedge clk);
    #1;
    check("refill_done_valid", 256'(wb_valid), 256'd0);
    wait_drain();

    // Second sop before eop discards the first instruction
    e = '{wid:2'd1, rd:6'd20, uuid:1'b1, pc:32'h304, tmask:8'hC3, data:mk_data(32'h200, 2'b11)};
    sb.push_back(e);
    send(1'b1, 1'b0, 1'b0, 4'hF, 2'd2, 6'd19, 1'b0, 32'h300, 1'b1, 32'h100);
    check("dsop_err_before", 256'(proto_err), 256'd0);
    send(1'b1, 1'b0, 1'b0, 4'h3, 2'd1, 6'd20, 1'b1, 32'h304, 1'b1, 32'h200);
    check("dsop_err_set", 256'(proto_err), 256'd1);
    send(1'b0, 1'b1, 1'b1, 4'hC, 2'd1, 6'd20, 1'b1, 32'h304, 1'b1, 32'h200);
    exp_ret++;
    check("dsop_retired", 256'(retired_count), 256'(exp_ret));
    wait_drain();

    // Asynchronous reset while collecting
    send(1'b1, 1'b0, 1'b0, 4'hF, 2'd1, 6'd1, 1'b0, 32'h400, 1'b1, 32'h900);
    #2;
    reset = 1'b1;
    #1;
    check("arst_wb_valid", 256'(wb_valid), 256'd0);
    check("arst_retired", 256'(retired_count), 256'd0);
    check("arst_proto_err", 256'(proto_err), 256'd0);
    check("arst_tmask", 256'(wb_tmask), 256'd0);
    exp_ret = 0;
    @(negedge clk);
    reset = 1'b0;
    e = '{wid:2'd2, rd:6'd33, uuid:1'b0, pc:32'h500, tmask:8'h1F, data:mk_data(32'hA00, 2'b11)};
    sb.push_back(e);
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 1'b0, 4'hF, 2'd2, 6'd33, 1'b0, 32'h500, 1'b1, 32'hA00);
    send(1'b0, 1'b1, 1'b1, 4'h1, 2'd2, 6'd33, 1'b0, 32'h500, 1'b1, 32'hA00);
    exp_ret++;
    check("post_rst_retired", 256'(retired_count), 256'(exp_ret));
    check("post_rst_err", 256'(proto_err), 256'd0);
    wait_drain();
    @(posedge clk);
    #1;

    // Continuation packet while idle is dropped
    send(1'b0, 1'b1, 1'b1, 4'hF, 2'd0, 6'd2, 1'b0, 32'h600, 1'b1, 32'hB00);
    check("drop_err", 256'(proto_err), 256'd1);
    check("drop_retired", 256'(retired_count), 256'(exp_ret));
    check("drop_wb_valid", 256'(wb_valid), 256'd0);
    repeat (3) @(posedge clk);
    #1;
    check("drop_idle_ready", 256'(commit_ready), 256'd1);

    // Warp-id mismatch flags an error but still merges under the latched wid
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_ret = 0;
    e = '{wid:2'd1, rd:6'd40, uuid:1'b1, pc:32'h700, tmask:8'hE7, data:mk_data(32'hC00, 2'b11)};
    sb.push_back(e);
    @(posedge clk);
    #1;
    send(1'b1, 1'b0, 1'b0, 4'h7, 2'd1, 6'd40, 1'b1, 32'h700, 1'b1, 32'hC00);
    check("wid_err_before", 256'(proto_err), 256'd0);
    send(1'b0, 1'b1, 1'b1, 4'hE, 2'd2, 6'd40, 1'b1, 32'h700, 1'b1, 32'hC00);
    exp_ret++;
    check("wid_err_set", 256'(proto_err), 256'd1);
    check("wid_retired", 256'(retired_count), 256'(exp_ret));
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
